// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: initiator-side controller for one single-port SRAM macro.
// It accepts word requests on a valid/ready channel and drives registered
// macro pins. Reads return data on a valid/ready response channel. Writes
// with a partial bit mask become an internal read-modify-write, because the
// macro ignores BW.
module sram_req_ctrl #(
    parameter int AS_W   = 2,
    parameter int AW_W   = 7,
    parameter int AC_W   = 2,
    parameter int DATA_W = 32
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AS_W+AW_W+AC_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    input  logic [DATA_W-1:0]           req_bmask,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_CEN,
    output logic                        mem_RDWEN,
    output logic [AS_W-1:0]             mem_AS,
    output logic [AW_W-1:0]             mem_AW,
    output logic [AC_W-1:0]             mem_AC,
    output logic [DATA_W-1:0]           mem_D,
    output logic [DATA_W-1:0]           mem_BW,
    input  logic [DATA_W-1:0]           mem_Q
);

    localparam int ADDR_W = AS_W + AW_W + AC_W;

    typedef enum logic [2:0] {
        IDLE, RD_SAMP, RD_CAP, RSP, RMW_SAMP, RMW_CAP, RMW_WR
    } state_t;

    state_t              state_q, state_d;
    logic                cen_q, cen_d;
    logic                rdwen_q, rdwen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic                accept;

    // The request port is open only in IDLE. It is held closed while reset is asserted.
    assign req_ready = (state_q == IDLE) && !RST;
    assign accept    = req_valid && req_ready;

    // The macro pins come straight from the registered copies.
    assign mem_CEN   = cen_q;
    assign mem_RDWEN = rdwen_q;
    assign mem_AC    = addr_q[AC_W-1:0];
    assign mem_AW    = addr_q[AC_W +: AW_W];
    assign mem_AS    = addr_q[AC_W+AW_W +: AS_W];
    assign mem_D     = d_q;
    assign mem_BW    = '1;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Next-state and next-pin decode. CEN returns high unless this edge loads an access.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cen_d       = 1'b1;
        rdwen_d     = rdwen_q;
        addr_d      = addr_q;
        d_d         = d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_we) begin
                        cen_d   = 1'b0;
                        rdwen_d = 1'b1;
                        addr_d  = req_addr;
                        state_d = RD_SAMP;
                    end else if (&req_bmask) begin
                        // A full write needs no read first, so the port stays open.
                        cen_d   = 1'b0;
                        rdwen_d = 1'b0;
                        addr_d  = req_addr;
                        d_d     = req_wdata;
                    end else if (req_bmask != '0) begin
                        // A partial write first reads the old word, then merges it.
                        cen_d   = 1'b0;
                        rdwen_d = 1'b1;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        mask_d  = req_bmask;
                        state_d = RMW_SAMP;
                    end
                    // A write with an all-zero mask is accepted and discarded.
                end
            end
            RD_SAMP:  state_d = RD_CAP;
            RD_CAP: begin
                rsp_rdata_d = mem_Q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            RMW_SAMP: state_d = RMW_CAP;
            RMW_CAP: begin
                cen_d   = 1'b0;
                rdwen_d = 1'b0;
                d_d     = (mem_Q & ~mask_q) | (wdata_q & mask_q);
                state_d = RMW_WR;
            end
            RMW_WR:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and pin registers, with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (RST) begin
            state_q     <= IDLE;
            cen_q       <= 1'b1;
            rdwen_q     <= 1'b1;
            addr_q      <= '0;
            d_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wdata_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            cen_q       <= cen_d;
            rdwen_q     <= rdwen_d;
            addr_q      <= addr_d;
            d_q         <= d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Testbench for sram_req_ctrl. It includes a behavioural macro model, a
// scoreboard of expected read data checked by a separate response monitor,
// and a log of every macro access.
module tb_sram_req_ctrl;

    localparam int AS_W   = 2;
    localparam int AW_W   = 7;
    localparam int AC_W   = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = AS_W + AW_W + AC_W;

    logic                CLK = 1'b0;
    logic                RST;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W-1:0]   req_bmask;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                mem_CEN;
    logic                mem_RDWEN;
    logic [AS_W-1:0]     mem_AS;
    logic [AW_W-1:0]     mem_AW;
    logic [AC_W-1:0]     mem_AC;
    logic [DATA_W-1:0]   mem_D;
    logic [DATA_W-1:0]   mem_BW;
    logic [DATA_W-1:0]   mem_Q;

    sram_req_ctrl #(.AS_W(AS_W), .AW_W(AW_W), .AC_W(AC_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_bmask(req_bmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_CEN(mem_CEN), .mem_RDWEN(mem_RDWEN), .mem_AS(mem_AS),
        .mem_AW(mem_AW), .mem_AC(mem_AC), .mem_D(mem_D), .mem_BW(mem_BW),
        .mem_Q(mem_Q)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Macro model: samples on the rising edge while CEN is low. Read data is valid the following cycle.
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] sram_q;
    always @(posedge CLK) begin
        if (!mem_CEN) begin
            if (!mem_RDWEN) sram[{mem_AS, mem_AW, mem_AC}] <= mem_D;
            else            sram_q <= sram[{mem_AS, mem_AW, mem_AC}];
        end
    end
    assign mem_Q = sram_q;

    // Access log: one entry per cycle in which the macro is enabled.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_t;
    acc_t acc_log[$];

    always @(negedge CLK) begin
        if (mem_CEN == 1'b0)
            acc_log.push_back('{we: ~mem_RDWEN, addr: {mem_AS, mem_AW, mem_AC}, data: mem_D});
    end

    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor: a handshake will occur at the next rising edge, so pop and compare now.
    always @(negedge CLK) begin
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%0h with no response outstanding", rsp_rdata);
            end else begin
                check("rsp_data", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present one request. Returns 1 time unit after the edge that accepted it.
    task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] bmask,
                        input bit expect_rsp, input logic [DATA_W-1:0] exp_data);
        int waited = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_bmask = bmask;
        if (expect_rsp) exp_q.push_back(exp_data);
        #0;
        while (req_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stuck at %b for addr 0x%0h", req_ready, addr);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: req_ready=%b rsp_valid=%b", req_ready, rsp_valid);
        end
    endtask

    initial begin
        RST       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_bmask = '0;
        rsp_ready = 1'b1;

        // 1. Reset held for three cycles while a request is offered.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_cen", 64'(mem_CEN), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_req_ready", 64'(req_ready), 64'd0);
        end
        RST       = 1'b0;
        req_valid = 1'b0;
        #1;
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // 2. Full write, then a read of the same address.
        send(1'b1, 11'h5A7, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b0, '0);
        check("wr_cen", 64'(mem_CEN), 64'd0);
        check("wr_rdwen", 64'(mem_RDWEN), 64'd0);
        check("wr_as", 64'(mem_AS), 64'd2);
        check("wr_aw", 64'(mem_AW), 64'h69);
        check("wr_ac", 64'(mem_AC), 64'd3);
        check("wr_d", 64'(mem_D), 64'hDEADBEEF);
        check("wr_bw", 64'(mem_BW), 64'hFFFFFFFF);
        tick();
        check("wr_cen_release", 64'(mem_CEN), 64'd1);
        send(1'b0, 11'h5A7, '0, '0, 1'b1, 32'hDEADBEEF);
        check("rd_cen", 64'(mem_CEN), 64'd0);
        check("rd_rdwen", 64'(mem_RDWEN), 64'd1);
        check("rd_valid_e0", 64'(rsp_valid), 64'd0);
        tick();
        check("rd_cen_e1", 64'(mem_CEN), 64'd1);
        check("rd_valid_e1", 64'(rsp_valid), 64'd0);
        tick();
        check("rd_valid_e2", 64'(rsp_valid), 64'd1);
        check("rd_data_e2", 64'(rsp_rdata), 64'hDEADBEEF);
        wait_idle();

        // 3. Partial write as a read-modify-write.
        send(1'b1, 11'h010, 32'h11223344, 32'hFFFFFFFF, 1'b0, '0);
        tick();
        acc_log.delete();
        send(1'b1, 11'h010, 32'hAABBCCDD, 32'h0000FF00, 1'b0, '0);
        check("rmw_ready_c1", 64'(req_ready), 64'd0);
        tick();
        check("rmw_ready_c2", 64'(req_ready), 64'd0);
        tick();
        check("rmw_ready_c3", 64'(req_ready), 64'd0);
        tick();
        check("rmw_ready_back", 64'(req_ready), 64'd1);
        tick();
        check("rmw_pulses", 64'(acc_log.size()), 64'd2);
        if (acc_log.size() >= 2) begin
            check("rmw_first_is_read", 64'(acc_log[0].we), 64'd0);
            check("rmw_read_addr", 64'(acc_log[0].addr), 64'h010);
            check("rmw_second_is_write", 64'(acc_log[1].we), 64'd1);
            check("rmw_write_addr", 64'(acc_log[1].addr), 64'h010);
            check("rmw_merge", 64'(acc_log[1].data), 64'h1122CC44);
        end
        send(1'b0, 11'h010, '0, '0, 1'b1, 32'h1122CC44);
        wait_idle();

        // 4. Response back-pressure.
        rsp_ready = 1'b0;
        send(1'b0, 11'h5A7, '0, '0, 1'b1, 32'hDEADBEEF);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_data", 64'(rsp_rdata), 64'hDEADBEEF);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_valid_drop", 64'(rsp_valid), 64'd0);
        check("bp_idle", 64'(req_ready), 64'd1);
        check("bp_single_pop", 64'(exp_q.size()), 64'd0);

        // 5. Back-to-back full writes, then readback.
        begin
            int start;
            acc_log.delete();
            start = cyc;
            for (int i = 0; i < 4; i++) begin
                send(1'b1, 11'(i), 32'hC0DE0000 | 32'(i), 32'hFFFFFFFF, 1'b0, '0);
                check("b2b_cen", 64'(mem_CEN), 64'd0);
                check("b2b_ac", 64'(mem_AC), 64'(i));
                check("b2b_d", 64'(mem_D), 64'hC0DE0000 | 64'(i));
            end
            check("b2b_cycles", 64'(cyc - start), 64'd4);
            tick();
            check("b2b_cen_release", 64'(mem_CEN), 64'd1);
            check("b2b_pulses", 64'(acc_log.size()), 64'd4);
            for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
                check("b2b_log_addr", 64'(acc_log[i].addr), 64'(i));
                check("b2b_log_data", 64'(acc_log[i].data), 64'hC0DE0000 | 64'(i));
            end
            for (int i = 0; i < 4; i++) begin
                send(1'b0, 11'(i), '0, '0, 1'b1, 32'hC0DE0000 | 32'(i));
                wait_idle();
            end
        end

        // 6. Zero-mask write, then reset in the middle of a read-modify-write.
        send(1'b1, 11'h020, 32'h55AA55AA, 32'hFFFFFFFF, 1'b0, '0);
        tick();
        acc_log.delete();
        send(1'b1, 11'h020, 32'hFFFFFFFF, 32'h00000000, 1'b0, '0);
        check("zmask_cen", 64'(mem_CEN), 64'd1);
        check("zmask_ready", 64'(req_ready), 64'd1);
        tick();
        check("zmask_no_pulse", 64'(acc_log.size()), 64'd0);
        send(1'b1, 11'h020, 32'h00000000, 32'h000000FF, 1'b0, '0);
        check("rmw_samp_busy", 64'(req_ready), 64'd0);
        RST = 1'b1;
        tick();
        check("mid_rst_cen", 64'(mem_CEN), 64'd1);
        check("mid_rst_rdwen", 64'(mem_RDWEN), 64'd1);
        check("mid_rst_addr", 64'({mem_AS, mem_AW, mem_AC}), 64'd0);
        check("mid_rst_d", 64'(mem_D), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd0);
        RST = 1'b0;
        tick();
        tick();
        check("mid_rst_ready_back", 64'(req_ready), 64'd1);
        check("mid_rst_pulses", 64'(acc_log.size()), 64'd1);
        if (acc_log.size() >= 1)
            check("mid_rst_only_read", 64'(acc_log[0].we), 64'd0);
        send(1'b0, 11'h020, '0, '0, 1'b1, 32'h55AA55AA);
        wait_idle();

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                tick();
                n++;
            end
        end
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
